seg_scan_controller: RTL
========================

// Module: seg_scan_controller
// PURPOSE
//   Time-multiplexed scan controller for a bank of common-anode 7-segment digits.
//   One shared hex-to-segment decode serves NUM_DIGITS digits by rotating digit
//   strobes at a fixed refresh rate. Accepts new display words over a valid/ready
//   handshake and commits them only at frame boundaries, so a scan never shows
//   a mix of old and new digits. Sits between the calculator core and board pins.
// PARAMETERS
//   NUM_DIGITS  4      digits scanned; legal 1..8
//   DIV         50000  clk cycles each digit stays lit; legal >= 2
//   BLANK_LZ    1      1 = blank leading zero digits (digit 0 is never blanked)
// PORTS
//   clk         in   1            system clock, rising edge
//   rst_n       in   1            async active-low reset
//   load_valid  in   1            load_data is valid
//   load_data   in   4*NUM_DIGITS nibble i = digit i (digit 0 = least significant)
//   load_ready  out  1            block can capture a new word
//   blank       in   1            1 = force entire display dark
//   digit_en_n  out  NUM_DIGITS   active-low one-hot digit strobe
//   seg_n       out  7            active-low segments, bit0=a .. bit6=g
//   frame_done  out  1            1-cycle pulse at end of each full scan
// BEHAVIOUR
//   Reset (async, immediate, also mid-operation): prescaler=0, index=0, display
//     reg=0, pending=0, digit_en_n=all 1, seg_n=7'h7F, frame_done=0.
//   Prescaler counts 0..DIV-1 and wraps; tick = (prescaler==DIV-1).
//   On tick the digit index advances 0..NUM_DIGITS-1 and wraps to 0.
//   frame_done=1 for the single cycle after a tick with index==NUM_DIGITS-1.
//   Handshake: load_ready = !pending (combinational). Capture on
//     load_valid && load_ready into buffer; pending=1 the next cycle.
//     load_data need not be held after capture; valid without ready is ignored.
//   Commit: on tick with index==NUM_DIGITS-1 and pending=1, display reg <= buffer
//     and pending <= 0 in the same cycle. Capture in the commit cycle is impossible
//     because pending=1 forces ready=0. Data captured mid-frame waits for the
//     next boundary.
//   Outputs are registered and lag index by 1 cycle:
//     nibble = display[4*index +: 4]; seg_n = decode(nibble) using patterns
//     0=1000000 1=1111001 2=0100100 3=0110000 4=0011001 5=0010010 6=0000010
//     7=1111000 8=0000000 9=0010000 A=0001000 B=0000011 C=1000110 D=0100001
//     E=0000110 F=0001110 (written g..a).
//   Digit i is dark when blank=1, or when BLANK_LZ=1, i!=0, and nibbles i..N-1
//     are all zero. Dark digit: digit_en_n=all 1 and seg_n=7'h7F.
//   Otherwise digit_en_n = ~(1<<index). blank takes effect 1 cycle after
//     assertion and does not stop prescaler, index or handshake.
//   Frame length is NUM_DIGITS*DIV cycles; no skipped or doubled digit on wrap.
// TESTING  (NUM_DIGITS=4, DIV=4, BLANK_LZ=1 unless noted)
//   Reset: hold rst_n=0 -> en=1111, seg=1111111. Release -> next cycle en=1110,
//     seg=1000000. Each digit lasts 4 cycles; frame_done occurs every 16 cycles.
//   Load 16'h12AF mid-frame -> ready=0 next cycle and display stays 0 until the
//     boundary. Then ready=1, digit0=0001110, digit1=0001000, digit2=0100100,
//     digit3=1111001.
//   Load 16'h0005 -> digits 1..3 dark (en bit high), digit0 seg=0010010.
//     Load 16'h0000 -> only digit0 lit showing 1000000.
//     With BLANK_LZ=0, 16'h0005 lights all four digits.
//   blank=1 mid-digit -> next cycle en=1111, seg=1111111. Index keeps advancing:
//     release on cycle k shows the digit for the current index.
//   Back-to-back: valid held with 16'h1111 then 16'h2222 -> 1111 captured, 2222
//     stalls (ready=0) until commit, is captured the cycle after, and shows one
//     frame later. No word is lost or duplicated.
//   Reset pulse mid-frame with pending=1 -> outputs dark asynchronously, ready=1,
//     pending word discarded, display shows 0 after release.

Source files
------------

// File: rtl/seg_scan_controller.sv
// rtl/seg_scan_controller.sv - multiplexed 7-segment scan controller with frame-aligned display updates
// One shared hex decoder drives NUM_DIGITS strobed digits; new words commit only at frame boundaries.
module seg_scan_controller #(
  parameter int NUM_DIGITS = 4,
  parameter int DIV        = 50000,
  parameter bit BLANK_LZ   = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load_valid,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  output logic                    load_ready,
  input  logic                    blank,
  output logic [NUM_DIGITS-1:0]   digit_en_n,
  output logic [6:0]              seg_n,
  output logic                    frame_done
);

  localparam int PW = $clog2(DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [PW-1:0]           presc;
  logic [IW-1:0]           index;
  logic [4*NUM_DIGITS-1:0] display;
  logic [4*NUM_DIGITS-1:0] buffer;
  logic                    pending;

  logic                    tick;
  logic                    last;
  logic [3:0]              nibble;
  logic [NUM_DIGITS-1:0]   onehot;
  logic [NUM_DIGITS-1:0]   lz_dark;
  logic                    upper_zero;
  logic                    dark;

  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'h0:    decode = 7'b1000000;
      4'h1:    decode = 7'b1111001;
      4'h2:    decode = 7'b0100100;
      4'h3:    decode = 7'b0110000;
      4'h4:    decode = 7'b0011001;
      4'h5:    decode = 7'b0010010;
      4'h6:    decode = 7'b0000010;
      4'h7:    decode = 7'b1111000;
      4'h8:    decode = 7'b0000000;
      4'h9:    decode = 7'b0010000;
      4'hA:    decode = 7'b0001000;
      4'hB:    decode = 7'b0000011;
      4'hC:    decode = 7'b1000110;
      4'hD:    decode = 7'b0100001;
      4'hE:    decode = 7'b0000110;
      default: decode = 7'b0001110;
    endcase
  endfunction

  assign tick       = (presc == PW'(DIV - 1));
  assign last       = (index == IW'(NUM_DIGITS - 1));
  assign load_ready = !pending;
  assign nibble     = display[4*index +: 4];

  // A digit is a leading zero when it and every more-significant nibble are zero.
  always_comb begin
    lz_dark    = '0;
    upper_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      upper_zero = upper_zero & (display[4*i +: 4] == 4'h0);
      lz_dark[i] = upper_zero;
    end
  end

  always_comb begin
    onehot        = '0;
    onehot[index] = 1'b1;
  end

  assign dark = blank | (BLANK_LZ & lz_dark[index]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc      <= '0;
      index      <= '0;
      display    <= '0;
      buffer     <= '0;
      pending    <= 1'b0;
      digit_en_n <= '1;
      seg_n      <= 7'h7F;
      frame_done <= 1'b0;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      if (tick) begin
        index <= last ? '0 : index + 1'b1;
      end
      frame_done <= tick & last;

      // Capture and commit are mutually exclusive: capture needs pending low, commit needs it high.
      if (load_valid && !pending) begin
        buffer  <= load_data;
        pending <= 1'b1;
      end else if (tick && last && pending) begin
        display <= buffer;
        pending <= 1'b0;
      end

      if (dark) begin
        digit_en_n <= '1;
        seg_n      <= 7'h7F;
      end else begin
        digit_en_n <= ~onehot;
        seg_n      <= decode(nibble);
      end
    end
  end

endmodule
